// File: rtl/fft_pkg.sv
// Shared FFT datapath types and default widths.
package fft_pkg;

   localparam int unsigned FFT_DATA_WD_DEF = 10;
   localparam int unsigned FFT_WN_WD_DEF   = 10;
   // Twiddles are Q2.F, so +1.0 is 2^F
   localparam int unsigned FFT_WN_FRAC_DEF = FFT_WN_WD_DEF - 2;

   typedef struct packed {
      logic signed [FFT_DATA_WD_DEF-1:0] re;
      logic signed [FFT_DATA_WD_DEF-1:0] im;
   } fft_cplx_t;

   typedef struct packed {
      logic inv;
      logic scale;
      logic rnd;
   } fft_mode_t;

endpackage

// File: rtl/fft_cmul_pipe.sv
// Registered complex multiplier p = b * w', with w' = conj(w) when conj is set.
module fft_cmul_pipe #(
   parameter int unsigned DATA_WD = 10,
   parameter int unsigned WN_WD   = 10
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             en,
   input  logic signed [DATA_WD-1:0]        b_re,
   input  logic signed [DATA_WD-1:0]        b_im,
   input  logic signed [WN_WD-1:0]          w_re,
   input  logic signed [WN_WD-1:0]          w_im,
   input  logic                             conj,
   output logic signed [DATA_WD+WN_WD+1:0]  p_re,
   output logic signed [DATA_WD+WN_WD+1:0]  p_im
);

   localparam int unsigned PW = DATA_WD + WN_WD + 2;

   logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
   logic signed [PW-1:0] p_re_c, p_im_c;

   // Widen before negating so conj of the most negative twiddle stays exact
   always_comb begin
      br_x   = PW'(b_re);
      bi_x   = PW'(b_im);
      wr_x   = PW'(w_re);
      wi_x   = conj ? -PW'(w_im) : PW'(w_im);
      p_re_c = br_x * wr_x - bi_x * wi_x;
      p_im_c = br_x * wi_x + bi_x * wr_x;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         p_re <= '0;
         p_im <= '0;
      end else if (en) begin
         p_re <= p_re_c;
         p_im <= p_im_c;
      end
   end

endmodule

// File: rtl/fft_bfly2_pipe.sv
// Three-stage radix-2 DIT butterfly with valid/ready flow control.
// Define FFT_BFLY2_SAT_EN for output saturation and overflow flag/counter.
module fft_bfly2_pipe
   import fft_pkg::*;
#(
   parameter int unsigned FFT_DATA_WD    = FFT_DATA_WD_DEF,
   parameter int unsigned FFT_WN_WD      = FFT_WN_WD_DEF,
   parameter int unsigned FFT_OVF_CNT_WD = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          din_vld,
   output logic                          din_rdy,
   input  logic signed [FFT_DATA_WD-1:0] din_1_re,
   input  logic signed [FFT_DATA_WD-1:0] din_1_im,
   input  logic signed [FFT_DATA_WD-1:0] din_2_re,
   input  logic signed [FFT_DATA_WD-1:0] din_2_im,
   input  logic signed [FFT_WN_WD-1:0]   wn_re,
   input  logic signed [FFT_WN_WD-1:0]   wn_im,
   input  logic                          mode_inv,
   input  logic                          mode_scale,
   input  logic                          mode_rnd,
   output logic                          dout_vld,
   input  logic                          dout_rdy,
   output logic signed [FFT_DATA_WD-1:0] dout_1_re,
   output logic signed [FFT_DATA_WD-1:0] dout_1_im,
   output logic signed [FFT_DATA_WD-1:0] dout_2_re,
   output logic signed [FFT_DATA_WD-1:0] dout_2_im,
   output logic                          ovf_flag,
   output logic [FFT_OVF_CNT_WD-1:0]     ovf_cnt,
   input  logic                          ovf_clr
);

   localparam int unsigned IW   = FFT_DATA_WD + FFT_WN_WD + 2;
   localparam int unsigned FRAC = FFT_WN_WD - 2;

   logic adv;

   // Whole pipe moves in lockstep; bubbles are kept, not squeezed out
   assign adv     = ~dout_vld | dout_rdy;
   assign din_rdy = adv;

   logic                          s1_vld;
   fft_mode_t                     s1_mode;
   logic signed [FFT_DATA_WD-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
   logic signed [FFT_WN_WD-1:0]   s1_wn_re, s1_wn_im;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_vld   <= 1'b0;
         s1_mode  <= '0;
         s1_a_re  <= '0;
         s1_a_im  <= '0;
         s1_b_re  <= '0;
         s1_b_im  <= '0;
         s1_wn_re <= '0;
         s1_wn_im <= '0;
      end else if (adv) begin
         s1_vld   <= din_vld;
         s1_mode  <= {mode_inv, mode_scale, mode_rnd};
         s1_a_re  <= din_1_re;
         s1_a_im  <= din_1_im;
         s1_b_re  <= din_2_re;
         s1_b_im  <= din_2_im;
         s1_wn_re <= wn_re;
         s1_wn_im <= wn_im;
      end
   end

   logic                          s2_vld;
   fft_mode_t                     s2_mode;
   logic signed [FFT_DATA_WD-1:0] s2_a_re, s2_a_im;
   logic signed [IW-1:0]          s2_p_re, s2_p_im;

   fft_cmul_pipe #(
      .DATA_WD (FFT_DATA_WD),
      .WN_WD   (FFT_WN_WD)
   ) u_cmul (
      .clk  (clk),
      .rstn (rstn),
      .en   (adv),
      .b_re (s1_b_re),
      .b_im (s1_b_im),
      .w_re (s1_wn_re),
      .w_im (s1_wn_im),
      .conj (s1_mode.inv),
      .p_re (s2_p_re),
      .p_im (s2_p_im)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_vld  <= 1'b0;
         s2_mode <= '0;
         s2_a_re <= '0;
         s2_a_im <= '0;
      end else if (adv) begin
         s2_vld  <= s1_vld;
         s2_mode <= s1_mode;
         s2_a_re <= s1_a_re;
         s2_a_im <= s1_a_im;
      end
   end

   logic signed [IW-1:0]          a_re_x, a_im_x, rnd_add_c;
   logic signed [IW-1:0]          sum_c [4];
   logic signed [IW-1:0]          shd_c [4];
   logic signed [FFT_DATA_WD-1:0] res_c [4];
   int unsigned                   sh_c;

`ifdef FFT_BFLY2_SAT_EN
   localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (FFT_DATA_WD - 1)) - 1);
   localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;
   logic [3:0] sat_c;
`endif

   // Lane order: out1.re, out1.im, out2.re, out2.im
   always_comb begin
      a_re_x    = IW'(s2_a_re) <<< FRAC;
      a_im_x    = IW'(s2_a_im) <<< FRAC;
      sh_c      = s2_mode.scale ? FRAC + 1 : FRAC;
      rnd_add_c = s2_mode.rnd ? (IW'(1) <<< (sh_c - 1)) : '0;
      sum_c[0]  = a_re_x + s2_p_re;
      sum_c[1]  = a_im_x + s2_p_im;
      sum_c[2]  = a_re_x - s2_p_re;
      sum_c[3]  = a_im_x - s2_p_im;
`ifdef FFT_BFLY2_SAT_EN
      sat_c     = '0;
`endif
      for (int i = 0; i < 4; i++) begin
         shd_c[i] = (sum_c[i] + rnd_add_c) >>> sh_c;
`ifdef FFT_BFLY2_SAT_EN
         if (shd_c[i] > SAT_MAX) begin
            res_c[i] = SAT_MAX[FFT_DATA_WD-1:0];
            sat_c[i] = 1'b1;
         end else if (shd_c[i] < SAT_MIN) begin
            res_c[i] = SAT_MIN[FFT_DATA_WD-1:0];
            sat_c[i] = 1'b1;
         end else begin
            res_c[i] = shd_c[i][FFT_DATA_WD-1:0];
         end
`else
         res_c[i] = shd_c[i][FFT_DATA_WD-1:0];
`endif
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dout_vld  <= 1'b0;
         dout_1_re <= '0;
         dout_1_im <= '0;
         dout_2_re <= '0;
         dout_2_im <= '0;
      end else if (adv) begin
         dout_vld  <= s2_vld;
         dout_1_re <= res_c[0];
         dout_1_im <= res_c[1];
         dout_2_re <= res_c[2];
         dout_2_im <= res_c[3];
      end
   end

`ifdef FFT_BFLY2_SAT_EN
   logic out_sat;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_sat <= 1'b0;
      end else if (adv) begin
         out_sat <= s2_vld & (|sat_c);
      end
   end

   // One count per saturating transaction, counted when it leaves; clear has priority
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_flag <= 1'b0;
         ovf_cnt  <= '0;
      end else if (ovf_clr) begin
         ovf_flag <= 1'b0;
         ovf_cnt  <= '0;
      end else if (dout_vld && dout_rdy && out_sat) begin
         ovf_flag <= 1'b1;
         if (ovf_cnt != '1) begin
            ovf_cnt <= ovf_cnt + FFT_OVF_CNT_WD'(1);
         end
      end
   end
`else
   logic unused_c;

   assign ovf_flag = 1'b0;
   assign ovf_cnt  = '0;
   assign unused_c = ^{shd_c[0], shd_c[1], shd_c[2], shd_c[3], ovf_clr};
`endif

endmodule

// File: tb/tb_fft_bfly2_pipe.sv
// Self-checking bench for fft_bfly2_pipe: vector table, random stall stream and reset cases.
module tb_fft_bfly2_pipe;
   import fft_pkg::*;

   localparam int DW = 10;

   typedef struct {
      fft_cplx_t               a;
      fft_cplx_t               b;
      logic signed [DW-1:0]    wr;
      logic signed [DW-1:0]    wi;
      logic                    inv;
      logic                    scale;
      logic                    rnd;
      fft_cplx_t               o1;
      fft_cplx_t               o2;
   } txn_t;

   typedef struct {
      fft_cplx_t o1;
      fft_cplx_t o2;
   } exp_t;

   logic                 clk;
   logic                 rstn;
   logic                 din_vld;
   logic                 din_rdy;
   logic signed [DW-1:0] din_1_re, din_1_im, din_2_re, din_2_im;
   logic signed [DW-1:0] wn_re, wn_im;
   logic                 mode_inv, mode_scale, mode_rnd;
   logic                 dout_vld;
   logic                 dout_rdy = 1'b1;
   logic signed [DW-1:0] dout_1_re, dout_1_im, dout_2_re, dout_2_im;
   logic                 ovf_flag;
   logic [15:0]          ovf_cnt;
   logic                 ovf_clr;

   fft_bfly2_pipe #(
      .FFT_DATA_WD    (10),
      .FFT_WN_WD      (10),
      .FFT_OVF_CNT_WD (16)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .din_vld    (din_vld),
      .din_rdy    (din_rdy),
      .din_1_re   (din_1_re),
      .din_1_im   (din_1_im),
      .din_2_re   (din_2_re),
      .din_2_im   (din_2_im),
      .wn_re      (wn_re),
      .wn_im      (wn_im),
      .mode_inv   (mode_inv),
      .mode_scale (mode_scale),
      .mode_rnd   (mode_rnd),
      .dout_vld   (dout_vld),
      .dout_rdy   (dout_rdy),
      .dout_1_re  (dout_1_re),
      .dout_1_im  (dout_1_im),
      .dout_2_re  (dout_2_re),
      .dout_2_im  (dout_2_im),
      .ovf_flag   (ovf_flag),
      .ovf_cnt    (ovf_cnt),
      .ovf_clr    (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t drv_exp;
   logic pat_en = 1'b0;
   int   pat_idx = 0;
   logic [3:0] pat_seq = 4'b1001;
   logic stall_prev = 1'b0;
   int   held [4];
   txn_t tbl[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic signed [DW-1:0] fit(input longint v);
`ifdef FFT_BFLY2_SAT_EN
      if (v > 511) return 10'sd511;
      if (v < -512) return 10'b10_0000_0000;
`endif
      return 10'(v);
   endfunction

   // Reference butterfly in plain integer arithmetic
   function automatic txn_t model(input txn_t t);
      longint br, bi, wr, wi, pr, pi;
      longint s [4];
      int     sh;
      txn_t   r;
      br = longint'(t.b.re);
      bi = longint'(t.b.im);
      wr = longint'(t.wr);
      wi = t.inv ? -longint'(t.wi) : longint'(t.wi);
      pr = br * wr - bi * wi;
      pi = br * wi + bi * wr;
      s[0] = longint'(t.a.re) * 256 + pr;
      s[1] = longint'(t.a.im) * 256 + pi;
      s[2] = longint'(t.a.re) * 256 - pr;
      s[3] = longint'(t.a.im) * 256 - pi;
      sh = int'(FFT_WN_FRAC_DEF) + (t.scale ? 1 : 0);
      for (int i = 0; i < 4; i++) begin
         if (t.rnd) s[i] = s[i] + (longint'(1) <<< (sh - 1));
         s[i] = s[i] >>> sh;
      end
      r = t;
      r.o1.re = fit(s[0]);
      r.o1.im = fit(s[1]);
      r.o2.re = fit(s[2]);
      r.o2.im = fit(s[3]);
      return r;
   endfunction

   function automatic txn_t mk(input int ar, input int ai, input int br, input int bi,
                               input int wr, input int wi, input logic inv,
                               input logic scale, input logic rnd,
                               input int o1r, input int o1i, input int o2r, input int o2i);
      txn_t t;
      t.a.re = 10'(ar);  t.a.im = 10'(ai);
      t.b.re = 10'(br);  t.b.im = 10'(bi);
      t.wr   = 10'(wr);  t.wi   = 10'(wi);
      t.inv  = inv;      t.scale = scale;   t.rnd = rnd;
      t.o1.re = 10'(o1r); t.o1.im = 10'(o1i);
      t.o2.re = 10'(o2r); t.o2.im = 10'(o2i);
      return t;
   endfunction

   task automatic send(input txn_t t);
      int  tries = 0;
      logic acc = 1'b0;
      din_1_re = t.a.re;  din_1_im = t.a.im;
      din_2_re = t.b.re;  din_2_im = t.b.im;
      wn_re = t.wr;       wn_im = t.wi;
      mode_inv = t.inv;   mode_scale = t.scale;  mode_rnd = t.rnd;
      drv_exp.o1 = t.o1;
      drv_exp.o2 = t.o2;
      din_vld = 1'b1;
      while (!acc && tries < 50) begin
         @(negedge clk);
         acc = din_rdy;
         @(posedge clk);
         #1;
         tries++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
      din_vld = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(posedge clk);
         k++;
      end
      chk(nm, sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #1;
      if (pat_en) begin
         dout_rdy = pat_seq[pat_idx[1:0]];
         pat_idx  = pat_idx + 1;
      end else begin
         dout_rdy = 1'b1;
      end
   end

   // Scoreboard monitor, sampling mid-cycle
   always @(negedge clk) begin
      if (!rstn) begin
         sb.delete();
         stall_prev = 1'b0;
      end else begin
         exp_t e;
         if (stall_prev) begin
            chk("hold_vld", int'(dout_vld), 1);
            chk("hold_1_re", dout_1_re, held[0]);
            chk("hold_1_im", dout_1_im, held[1]);
            chk("hold_2_re", dout_2_re, held[2]);
            chk("hold_2_im", dout_2_im, held[3]);
         end
         chk("din_rdy", int'(din_rdy), int'(!dout_vld || dout_rdy));
         if (din_vld && din_rdy) sb.push_back(drv_exp);
         if (dout_vld && dout_rdy) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("out1_re", dout_1_re, e.o1.re);
               chk("out1_im", dout_1_im, e.o1.im);
               chk("out2_re", dout_2_re, e.o2.re);
               chk("out2_im", dout_2_im, e.o2.im);
            end
         end
         stall_prev = dout_vld && !dout_rdy;
         held[0] = dout_1_re;
         held[1] = dout_1_im;
         held[2] = dout_2_re;
         held[3] = dout_2_im;
      end
   end

   initial begin
      txn_t ovf_v;
      txn_t r;
      rstn = 1'b0;
      din_vld = 1'b0;
      din_1_re = '0; din_1_im = '0; din_2_re = '0; din_2_im = '0;
      wn_re = '0; wn_im = '0;
      mode_inv = 1'b0; mode_scale = 1'b0; mode_rnd = 1'b0;
      ovf_clr = 1'b0;

      tbl.push_back(mk(100, 0, 50, 0, 256, 0, 0, 0, 0, 150, 0, 50, 0));
      tbl.push_back(mk(10, 20, 0, 100, 0, -256, 0, 0, 0, 110, 20, -90, 20));
      tbl.push_back(mk(10, 20, 0, 100, 0, -256, 1, 0, 0, -90, 20, 110, 20));
      tbl.push_back(mk(3, 0, 0, 0, 256, 0, 0, 1, 0, 1, 0, 1, 0));
      tbl.push_back(mk(3, 0, 0, 0, 256, 0, 0, 1, 1, 2, 0, 2, 0));
      tbl.push_back(mk(-3, 0, 0, 0, 256, 0, 0, 1, 0, -2, 0, -2, 0));
      tbl.push_back(mk(-3, 0, 0, 0, 256, 0, 0, 1, 1, -1, 0, -1, 0));
`ifdef FFT_BFLY2_SAT_EN
      ovf_v = mk(511, 0, 511, 0, 256, 0, 0, 0, 0, 511, 0, 0, 0);
`else
      ovf_v = mk(511, 0, 511, 0, 256, 0, 0, 0, 0, -2, 0, 0, 0);
`endif
      tbl.push_back(ovf_v);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout_vld", int'(dout_vld), 0);
      chk("rst_dout_1_re", dout_1_re, 0);
      chk("rst_dout_2_im", dout_2_im, 0);
      chk("rst_ovf_flag", int'(ovf_flag), 0);
      chk("rst_ovf_cnt", int'(ovf_cnt), 0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) send(tbl[i]);
      drain("drain_table");

`ifdef FFT_BFLY2_SAT_EN
      chk("ovf_flag_set", int'(ovf_flag), 1);
      chk("ovf_cnt_one", int'(ovf_cnt), 1);
`else
      chk("ovf_flag_off", int'(ovf_flag), 0);
      chk("ovf_cnt_off", int'(ovf_cnt), 0);
`endif
      ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      ovf_clr = 1'b0;
      chk("ovf_flag_clr", int'(ovf_flag), 0);
      chk("ovf_cnt_clr", int'(ovf_cnt), 0);

      // Clear held across a saturating transfer must win
      ovf_clr = 1'b1;
      send(ovf_v);
      drain("drain_clr_win");
      ovf_clr = 1'b0;
      @(posedge clk);
      #1;
      chk("clr_win_flag", int'(ovf_flag), 0);
      chk("clr_win_cnt", int'(ovf_cnt), 0);

      // Random stream under a 1,0,0,1 ready pattern
      pat_en = 1'b1;
      for (int n = 0; n < 12; n++) begin
         r.a.re = 10'($urandom);  r.a.im = 10'($urandom);
         r.b.re = 10'($urandom);  r.b.im = 10'($urandom);
         r.wr   = 10'($urandom);  r.wi   = 10'($urandom);
         r.inv  = 1'($urandom);   r.scale = 1'($urandom);  r.rnd = 1'($urandom);
         r = model(r);
         send(r);
      end
      drain("drain_stream");
      pat_en = 1'b0;
      @(posedge clk);
      #1;

      // Reset with three transactions in flight
      send(tbl[0]);
      send(tbl[1]);
      send(tbl[2]);
      rstn = 1'b0;
      #1;
      chk("midrst_dout_vld", int'(dout_vld), 0);
      chk("midrst_dout_1_re", dout_1_re, 0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_idle", int'(dout_vld), 0);
      end
      @(posedge clk);
      #1;
      send(tbl[3]);
      drain("drain_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
